// File: rtl/sphere_pair_scheduler.sv
// All-pairs sphere collision sequencer that owns one shared dCollideSpheres core.
// Optional watchdog on the core handshake is built only when SCHED_TIMEOUT_EN is defined.
module sphere_pair_scheduler #(
    parameter int MAX_SPHERES    = 8,
    parameter int IDXW           = 3,
    parameter int RST_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wr_en,
    input  logic [IDXW-1:0] wr_addr,
    input  logic [1:0]      wr_field,
    input  logic [31:0]     wr_data,
    input  logic [IDXW:0]   n_spheres,
    input  logic            start,
    output logic            busy,
    output logic            done,
    output logic [15:0]     contact_count,
    output logic [31:0]     core_x1,
    output logic [31:0]     core_y1,
    output logic [31:0]     core_z1,
    output logic [31:0]     core_r1,
    output logic [31:0]     core_x2,
    output logic [31:0]     core_y2,
    output logic [31:0]     core_z2,
    output logic [31:0]     core_r2,
    output logic            core_rst,
    input  logic            core_done,
    input  logic [31:0]     core_ret,
    input  logic [31:0]     core_depth,
    input  logic [31:0]     core_nx,
    input  logic [31:0]     core_ny,
    input  logic [31:0]     core_nz,
    output logic            res_valid,
    input  logic            res_ready,
    output logic [IDXW-1:0] res_i,
    output logic [IDXW-1:0] res_j,
    output logic [31:0]     res_depth,
    output logic [31:0]     res_nx,
    output logic [31:0]     res_ny,
    output logic [31:0]     res_nz,
    output logic            timeout
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ISSUE  = 3'd1,
        ST_WAIT   = 3'd2,
        ST_EMIT   = 3'd3,
        ST_FINISH = 3'd4
    } state_t;

    localparam int RCW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [IDXW:0] MAX_N = (IDXW+1)'(MAX_SPHERES);
    localparam logic [IDXW:0] ONE_N = (IDXW+1)'(1);
    localparam logic [IDXW:0] TWO_N = (IDXW+1)'(2);

    if (MAX_SPHERES != (1 << IDXW) || RST_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("sphere_pair_scheduler: inconsistent parameters");
    end

    state_t                state_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  core_rst_q;
    logic                  res_valid_q;
    logic [15:0]           cnt_q;
    logic [IDXW:0]         n_q;
    logic [IDXW-1:0]       i_q;
    logic [IDXW-1:0]       j_q;
    logic [RCW-1:0]        rcnt_q;
    logic [3:0][31:0]      op1_q;
    logic [3:0][31:0]      op2_q;
    logic [IDXW-1:0]       res_i_q;
    logic [IDXW-1:0]       res_j_q;
    logic [31:0]           res_depth_q;
    logic [31:0]           res_nx_q;
    logic [31:0]           res_ny_q;
    logic [31:0]           res_nz_q;
    logic [31:0]           tbl_q [MAX_SPHERES][4];

    logic [IDXW:0]         n_clamp_s;
    logic [IDXW-1:0]       nxt_i_s;
    logic [IDXW-1:0]       nxt_j_s;
    logic                  adv_last_s;
    logic [IDXW-1:0]       ld_i_s;
    logic [IDXW-1:0]       ld_j_s;
    logic [3:0][31:0]      op1_s;
    logic [3:0][31:0]      op2_s;
    logic                  wr_ok_s;
    logic                  adv_s;
    logic                  timed_out_s;

`ifdef SCHED_TIMEOUT_EN
    localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TCW-1:0] tcnt_q;
    logic           timeout_q;

    assign timed_out_s = (tcnt_q == TCW'(TIMEOUT_CYCLES - 1));
    assign timeout     = timeout_q;
`else
    assign timed_out_s = 1'b0;
    assign timeout     = 1'b0;
`endif

    assign wr_ok_s = wr_en && !busy_q;

    // Pair enumeration: next (i,j) in lexicographic order and the clamped pass length
    always_comb begin
        nxt_i_s    = i_q;
        nxt_j_s    = j_q;
        adv_last_s = 1'b0;
        if (n_spheres > MAX_N) begin
            n_clamp_s = MAX_N;
        end else begin
            n_clamp_s = n_spheres;
        end
        if ({1'b0, j_q} < (n_q - ONE_N)) begin
            nxt_j_s = j_q + IDXW'(1);
        end else if (({1'b0, i_q} + TWO_N) < n_q) begin
            nxt_i_s = i_q + IDXW'(1);
            nxt_j_s = i_q + IDXW'(2);
        end else begin
            adv_last_s = 1'b1;
        end
    end

    // Operand fetch; a write in the start cycle is forwarded so the pass sees it
    always_comb begin
        if (state_q == ST_IDLE) begin
            ld_i_s = '0;
            ld_j_s = IDXW'(1);
        end else begin
            ld_i_s = nxt_i_s;
            ld_j_s = nxt_j_s;
        end
        for (int f = 0; f < 4; f++) begin
            if (wr_ok_s && wr_addr == ld_i_s && wr_field == 2'(f)) begin
                op1_s[f] = wr_data;
            end else begin
                op1_s[f] = tbl_q[ld_i_s][f];
            end
            if (wr_ok_s && wr_addr == ld_j_s && wr_field == 2'(f)) begin
                op2_s[f] = wr_data;
            end else begin
                op2_s[f] = tbl_q[ld_j_s][f];
            end
        end
    end

    // Pair completes: core said no contact, result was taken, or the watchdog fired
    always_comb begin
        case (state_q)
            ST_WAIT: begin
                if (core_done) begin
                    adv_s = (core_ret == 32'd0);
                end else begin
                    adv_s = timed_out_s;
                end
            end
            ST_EMIT: adv_s = res_ready;
            default: adv_s = 1'b0;
        endcase
    end

    // Sphere table storage; contents are intentionally left unreset
    always_ff @(posedge clk) begin
        if (wr_ok_s) begin
            tbl_q[wr_addr][wr_field] <= wr_data;
        end else begin
            tbl_q[wr_addr][wr_field] <= tbl_q[wr_addr][wr_field];
        end
    end

    // Pass sequencer with registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            core_rst_q  <= 1'b1;
            res_valid_q <= 1'b0;
            cnt_q       <= 16'd0;
            n_q         <= '0;
            i_q         <= '0;
            j_q         <= '0;
            rcnt_q      <= '0;
            op1_q       <= '0;
            op2_q       <= '0;
            res_i_q     <= '0;
            res_j_q     <= '0;
            res_depth_q <= 32'd0;
            res_nx_q    <= 32'd0;
            res_ny_q    <= 32'd0;
            res_nz_q    <= 32'd0;
`ifdef SCHED_TIMEOUT_EN
            tcnt_q      <= '0;
            timeout_q   <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    core_rst_q <= 1'b0;
                    if (start) begin
                        busy_q <= 1'b1;
                        n_q    <= n_clamp_s;
                        cnt_q  <= 16'd0;
`ifdef SCHED_TIMEOUT_EN
                        timeout_q <= 1'b0;
`endif
                        if (n_clamp_s < TWO_N) begin
                            state_q <= ST_FINISH;
                        end else begin
                            i_q        <= '0;
                            j_q        <= IDXW'(1);
                            op1_q      <= op1_s;
                            op2_q      <= op2_s;
                            core_rst_q <= 1'b1;
                            rcnt_q     <= '0;
                            state_q    <= ST_ISSUE;
                        end
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_ISSUE: begin
                    if (rcnt_q == RCW'(RST_CYCLES - 1)) begin
                        core_rst_q <= 1'b0;
                        state_q    <= ST_WAIT;
`ifdef SCHED_TIMEOUT_EN
                        tcnt_q     <= '0;
`endif
                    end else begin
                        rcnt_q <= rcnt_q + RCW'(1);
                    end
                end
                ST_WAIT: begin
                    if (core_done) begin
                        res_i_q     <= i_q;
                        res_j_q     <= j_q;
                        res_depth_q <= core_depth;
                        res_nx_q    <= core_nx;
                        res_ny_q    <= core_ny;
                        res_nz_q    <= core_nz;
                        if (core_ret != 32'd0) begin
                            res_valid_q <= 1'b1;
                            state_q     <= ST_EMIT;
                            if (cnt_q != 16'hFFFF) begin
                                cnt_q <= cnt_q + 16'd1;
                            end else begin
                                cnt_q <= cnt_q;
                            end
                        end else begin
                            state_q <= ST_WAIT;
                        end
                    end
`ifdef SCHED_TIMEOUT_EN
                    else if (timed_out_s) begin
                        timeout_q <= 1'b1;
                    end else begin
                        tcnt_q <= tcnt_q + TCW'(1);
                    end
`else
                    else begin
                        state_q <= ST_WAIT;
                    end
`endif
                end
                ST_EMIT: begin
                    if (res_ready) begin
                        res_valid_q <= 1'b0;
                    end else begin
                        res_valid_q <= 1'b1;
                    end
                end
                ST_FINISH: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
            // Overrides the case above when the current pair is finished
            if (adv_s) begin
                if (adv_last_s) begin
                    state_q <= ST_FINISH;
                end else begin
                    i_q        <= nxt_i_s;
                    j_q        <= nxt_j_s;
                    op1_q      <= op1_s;
                    op2_q      <= op2_s;
                    core_rst_q <= 1'b1;
                    rcnt_q     <= '0;
                    state_q    <= ST_ISSUE;
                end
            end
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign contact_count = cnt_q;
    assign core_rst      = core_rst_q;
    assign core_x1       = op1_q[0];
    assign core_y1       = op1_q[1];
    assign core_z1       = op1_q[2];
    assign core_r1       = op1_q[3];
    assign core_x2       = op2_q[0];
    assign core_y2       = op2_q[1];
    assign core_z2       = op2_q[2];
    assign core_r2       = op2_q[3];
    assign res_valid     = res_valid_q;
    assign res_i         = res_i_q;
    assign res_j         = res_j_q;
    assign res_depth     = res_depth_q;
    assign res_nx        = res_nx_q;
    assign res_ny        = res_ny_q;
    assign res_nz        = res_nz_q;

endmodule

// File: tb/tb_sphere_pair_scheduler.sv
// Scoreboard bench for sphere_pair_scheduler with a behavioural collision core model.
module tb_sphere_pair_scheduler;
    localparam int RC = 2;
    localparam int TO = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic wr_en = 1'b0;
    logic [2:0] wr_addr = 3'd0;
    logic [1:0] wr_field = 2'd0;
    logic [31:0] wr_data = 32'd0;
    logic [3:0] n_spheres = 4'd0;
    logic start = 1'b0;
    logic busy, done, core_rst, res_valid, timeout;
    logic [15:0] contact_count;
    logic [31:0] core_x1, core_y1, core_z1, core_r1, core_x2, core_y2, core_z2, core_r2;
    logic core_done = 1'b0;
    logic [31:0] core_ret = 32'd0, core_depth = 32'd0, core_nx = 32'd0, core_ny = 32'd0, core_nz = 32'd0;
    logic res_ready = 1'b0;
    logic [2:0] res_i, res_j;
    logic [31:0] res_depth, res_nx, res_ny, res_nz;

    sphere_pair_scheduler #(.MAX_SPHERES(8), .IDXW(3), .RST_CYCLES(RC), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_field(wr_field), .wr_data(wr_data),
        .n_spheres(n_spheres), .start(start), .busy(busy), .done(done), .contact_count(contact_count),
        .core_x1(core_x1), .core_y1(core_y1), .core_z1(core_z1), .core_r1(core_r1),
        .core_x2(core_x2), .core_y2(core_y2), .core_z2(core_z2), .core_r2(core_r2),
        .core_rst(core_rst), .core_done(core_done), .core_ret(core_ret), .core_depth(core_depth),
        .core_nx(core_nx), .core_ny(core_ny), .core_nz(core_nz), .res_valid(res_valid), .res_ready(res_ready),
        .res_i(res_i), .res_j(res_j), .res_depth(res_depth), .res_nx(res_nx), .res_ny(res_ny), .res_nz(res_nz),
        .timeout(timeout));

    always #5 clk = ~clk;

    typedef struct { int i; int j; logic [31:0] d, nx, ny, nz; } res_t;
    res_t exp_q[$];
    logic [31:0] tbl [8][4];
    bit coll [8][8];
    int cur_n = 0, exp_cnt = 0, exp_pairs = 0;
    bit hang_en = 0, junk_en = 0, rand_ready = 0;
    int hang_a = 0, hang_b = 0, stall_req = 0;
    int checks = 0, passed = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act === exp_v) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp_v, $time);
    endtask

    // Reference: every i<j in order, reported only when the pair collides
    task automatic build_exp(input int n);
        int ne;
        res_t e;
        ne = (n > 8) ? 8 : n;
        cur_n = ne;
        exp_q.delete();
        exp_cnt = 0;
        exp_pairs = 0;
        for (int i = 0; i < ne; i++)
            for (int j = i + 1; j < ne; j++) begin
                exp_pairs++;
                if (coll[i][j] && !(hang_en && i == hang_a && j == hang_b)) begin
                    e.i = i; e.j = j;
                    e.d = tbl[i][0] ^ tbl[j][1];
                    e.nx = tbl[i][1] + tbl[j][2];
                    e.ny = tbl[i][2] - tbl[j][3];
                    e.nz = tbl[i][3] ^ tbl[j][0] ^ 32'h5A5A5A5A;
                    exp_q.push_back(e);
                    exp_cnt++;
                end
            end
    endtask

    // Collision core model: identifies spheres by x, random latency, junk while in restart
    int lat = 0, ca, cb;
    bit pend = 0;
    always @(negedge clk) begin
        if (rst || core_rst) begin
            pend = 1'b1;
            lat = $urandom_range(0, 4);
            core_done = junk_en && !rst;
            core_ret = 32'h1;
            core_depth = $urandom; core_nx = $urandom; core_ny = $urandom; core_nz = $urandom;
        end else if (pend) begin
            if (lat > 0) begin
                lat--;
                core_done = 1'b0;
            end else begin
                ca = -1; cb = -1;
                for (int k = 0; k < cur_n; k++) begin
                    if (tbl[k][0] === core_x1) ca = k;
                    if (tbl[k][0] === core_x2) cb = k;
                end
                if (hang_en && ca == hang_a && cb == hang_b) core_done = 1'b0;
                else begin
                    core_ret = (ca >= 0 && cb >= 0 && coll[ca][cb]) ? (32'h1 << $urandom_range(0, 31)) : 32'h0;
                    core_depth = core_x1 ^ core_y2;
                    core_nx = core_y1 + core_z2;
                    core_ny = core_z1 - core_r2;
                    core_nz = core_r1 ^ core_x2 ^ 32'h5A5A5A5A;
                    core_done = 1'b1;
                    pend = 1'b0;
                end
            end
        end
    end

    // Result monitor and ready driver; compares the queue head every valid cycle
    res_t e_m;
    always @(negedge clk) begin
        if (!rst) begin
            if (stall_req > 0 && res_valid) begin
                res_ready = 1'b0;
                stall_req--;
            end else res_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (res_valid) begin
                chk("no_issue_during_emit", core_rst, 1'b0);
                if (exp_q.size() == 0) chk("unexpected_result", res_valid, 1'b0);
                else begin
                    e_m = exp_q[0];
                    chk("res_pair", {res_i, res_j}, {e_m.i[2:0], e_m.j[2:0]});
                    chk("res_depth", res_depth, e_m.d);
                    chk("res_nx", res_nx, e_m.nx);
                    chk("res_ny", res_ny, e_m.ny);
                    chk("res_nz", res_nz, e_m.nz);
                    if (res_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic write_sphere(input int k, input logic [31:0] x, y, z, r);
        logic [31:0] v [4];
        v[0] = x; v[1] = y; v[2] = z; v[3] = r;
        for (int f = 0; f < 4; f++) begin
            @(negedge clk);
            wr_en = 1'b1; wr_addr = 3'(k); wr_field = 2'(f); wr_data = v[f];
            tbl[k][f] = v[f];
        end
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic run_pass(input int n, input bit with_wr);
        int hi, pulses, w;
        @(negedge clk);
        if (with_wr) begin
            tbl[0][1] = $urandom;
            wr_en = 1'b1; wr_addr = 3'd0; wr_field = 2'd1; wr_data = tbl[0][1];
        end
        build_exp(n);
        n_spheres = 4'(n);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wr_en = 1'b0;
        chk("busy_after_start", busy, 1'b1);
        hi = 0; pulses = 0;
        for (w = 0; w < 3000; w++) begin
            if (w > 0) @(negedge clk);
            if (core_rst) hi++;
            else if (hi > 0) begin
                chk("core_rst_len", hi, RC);
                pulses++;
                hi = 0;
            end
            if (done) break;
        end
        chk("done_seen", done, 1'b1);
        if (cur_n < 2) chk("done_latency", w, 1);
        chk("busy_low_at_done", busy, 1'b0);
        chk("rst_pulses", pulses, exp_pairs);
        chk("contact_count", contact_count, exp_cnt);
        chk("results_drained", exp_q.size(), 0);
`ifdef SCHED_TIMEOUT_EN
        chk("timeout_flag", timeout, hang_en);
`else
        chk("timeout_tied_low", timeout, 1'b0);
`endif
        @(negedge clk);
        chk("done_one_cycle", done, 1'b0);
    endtask

    task automatic random_table();
        for (int k = 0; k < 8; k++) begin
            logic [31:0] rx;
            rx = $urandom;
            write_sphere(k, {rx[31:3], 3'(k)}, $urandom, $urandom, $urandom);
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_core_rst", core_rst, 1'b1);
        chk("rst_res_valid", res_valid, 1'b0);
        chk("rst_count", contact_count, 16'd0);
        chk("rst_res_depth", res_depth, 32'd0);
        chk("rst_core_x1", core_x1, 32'd0);
        chk("rst_timeout", timeout, 1'b0);
        rst = 1'b0;

        // Two touching unit-diameter spheres
        write_sphere(0, 32'hBEFC3611, 32'h0, 32'h3FC00000, 32'h3F000000);
        write_sphere(1, 32'h3EFC3611, 32'h0, 32'h3FC00000, 32'h3F000000);
        coll[0][1] = 1'b1;
        run_pass(2, 1'b0);

        // All pairs collide, N=4
        random_table();
        for (int i = 0; i < 8; i++) for (int j = 0; j < 8; j++) coll[i][j] = 1'b1;
        run_pass(4, 1'b0);

        // Only (1,3) collides; also a write committed in the start cycle
        for (int i = 0; i < 8; i++) for (int j = 0; j < 8; j++) coll[i][j] = 1'b0;
        coll[1][3] = 1'b1;
        run_pass(4, 1'b1);

        run_pass(0, 1'b0);
        run_pass(1, 1'b0);

        // Long stall on the first result; start/write attempts while busy
        for (int i = 0; i < 8; i++) for (int j = 0; j < 8; j++) coll[i][j] = 1'b1;
        stall_req = 10;
        fork
            run_pass(4, 1'b0);
            begin
                for (int c = 0; c < 200 && !res_valid; c++) @(negedge clk);
                chk("stall_saw_valid", res_valid, 1'b1);
                @(negedge clk);
                start = 1'b1; n_spheres = 4'd2;
                wr_en = 1'b1; wr_addr = 3'd3; wr_field = 2'd0; wr_data = 32'hDEAD0003;
                @(negedge clk);
                start = 1'b0; wr_en = 1'b0; n_spheres = 4'd4;
            end
        join
        stall_req = 0;

        // Asynchronous reset while waiting on the core
        build_exp(4);
        @(negedge clk);
        n_spheres = 4'd4; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (contact_count != 16'd0 && busy && !core_rst && !res_valid) begin
                found = 1'b1;
                break;
            end
        end
        chk("reached_wait", found, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("arst_busy", busy, 1'b0);
        chk("arst_core_rst", core_rst, 1'b1);
        chk("arst_res_valid", res_valid, 1'b0);
        chk("arst_count", contact_count, 16'd0);
        chk("arst_res_ij", {res_i, res_j}, 6'd0);
        chk("arst_core_r2", core_r2, 32'd0);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;

`ifdef SCHED_TIMEOUT_EN
        hang_en = 1'b1; hang_a = 0; hang_b = 2;
        run_pass(3, 1'b0);
        hang_en = 1'b0;
`endif

        // Randomized passes, including a clamped sphere count
        rand_ready = 1'b1;
        for (int p = 0; p < 4; p++) begin
            random_table();
            for (int i = 0; i < 8; i++) for (int j = 0; j < 8; j++) coll[i][j] = 1'($urandom_range(0, 1));
            junk_en = 1'($urandom_range(0, 1));
            run_pass((p == 0) ? 12 : $urandom_range(0, 8), 1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
